// File: rtl/cnt_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cnt_slot_arbiter
// Brief    : Round-robin time-slot arbiter granting one shared W-bit counter.
// Revision : 1.0
// ============================================================================
module cnt_slot_arbiter #(
   parameter int NREQ = 4,
   parameter int W    = 3,
   parameter int SLOT = 8
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ-1:0]         rel,
   output logic [NREQ-1:0]         gnt,
   output logic                    busy,
   output logic [$clog2(NREQ)-1:0] owner,
   output logic [W-1:0]            cnt,
   output logic                    slot_end
);

   localparam int IW = $clog2(NREQ);
   localparam logic [W-1:0]  c_last = W'(SLOT - 1);
   localparam logic [IW-1:0] c_top  = IW'(NREQ - 1);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [NREQ-1:0] r_gnt,   w_gnt_nxt;
   logic            r_busy,  w_busy_nxt;
   logic [IW-1:0]   r_owner, w_owner_nxt;
   logic [W-1:0]    r_cnt,   w_cnt_nxt;
   logic [IW-1:0]   r_ptr,   w_ptr_nxt;

   logic            w_own_end;
   logic [IW-1:0]   w_succ;
   logic [IW-1:0]   w_start;
   logic [NREQ-1:0] w_cand;
   logic            w_found;
   logic [IW-1:0]   w_sel;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state <= S_IDLE;
         r_gnt   <= '0;
         r_busy  <= 1'b0;
         r_owner <= '0;
         r_cnt   <= '0;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_gnt   <= w_gnt_nxt;
         r_busy  <= w_busy_nxt;
         r_owner <= w_owner_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ptr   <= w_ptr_nxt;
      end
   end

   always_comb begin
      w_own_end = (r_state == S_GRANT) &&
                  ((r_cnt == c_last) || rel[r_owner] || !req[r_owner]);
      w_succ    = (r_owner == c_top) ? '0 : r_owner + 1'b1;

      // At a slot end the search begins after the owner; a releasing owner is excluded
      w_cand  = req;
      w_start = r_ptr;
      if (r_state == S_GRANT) begin
         w_start = w_succ;
         if (rel[r_owner]) w_cand[r_owner] = 1'b0;
      end

      w_found = 1'b0;
      w_sel   = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!w_found && w_cand[(int'(w_start) + k) % NREQ]) begin
            w_found = 1'b1;
            w_sel   = IW'((int'(w_start) + k) % NREQ);
         end
      end

      w_state_nxt = r_state;
      w_gnt_nxt   = r_gnt;
      w_busy_nxt  = r_busy;
      w_owner_nxt = r_owner;
      w_cnt_nxt   = r_cnt;
      w_ptr_nxt   = r_ptr;

      if (r_state == S_GRANT && !w_own_end) begin
         w_cnt_nxt = r_cnt + 1'b1;
      end else if (r_state == S_GRANT || w_found) begin
         if (r_state == S_GRANT) w_ptr_nxt = w_succ;
         if (w_found) begin
            w_state_nxt        = S_GRANT;
            w_gnt_nxt          = '0;
            w_gnt_nxt[w_sel]   = 1'b1;
            w_busy_nxt         = 1'b1;
            w_owner_nxt        = w_sel;
            w_cnt_nxt          = '0;
         end else begin
            w_state_nxt = S_IDLE;
            w_gnt_nxt   = '0;
            w_busy_nxt  = 1'b0;
            w_owner_nxt = '0;
            w_cnt_nxt   = '0;
         end
      end
   end

   assign gnt      = r_gnt;
   assign busy     = r_busy;
   assign owner    = r_owner;
   assign cnt      = r_cnt;
   assign slot_end = w_own_end;

endmodule
`default_nettype wire
